// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO unit: default geometry and pointer width.
package fifo_pkg;

    localparam int FIFO_ADDRESS_WIDTH = 13;
    localparam int FIFO_DATA_WIDTH    = 32;
    // Pointers carry one extra wrap bit above the RAM address.
    localparam int FIFO_PTR_WIDTH     = FIFO_ADDRESS_WIDTH + 1;

endpackage : fifo_pkg

// File: rtl/ram_dual.sv
// Simple dual-port RAM: synchronous write port, registered read address
// with a combinational read from that registered address. Contents are
// never reset.
module ram_dual #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] raddr_q;

    // Write the addressed word and capture the read address every edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        raddr_q <= raddr;
    end

    assign rdata = mem[raddr_q];

endmodule : ram_dual

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller around ram_dual: pointers, occupancy,
// full/empty, sticky overflow/underflow and synchronous flush.
// Optional build macro FIFOCTRL_THRESH_EN adds registered almost-full and
// almost-empty flags; without it both outputs are tied low.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = FIFO_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int AFULL_LEVEL   = 2 ** 13 - 4,
    parameter int AEMPTY_LEVEL  = 4
) (
    input  logic                     fifoctrl_clk_i,
    input  logic                     fifoctrl_rstn_i,
    input  logic                     fifoctrl_flush_i,
    input  logic                     fifoctrl_push_i,
    input  logic [DATA_WIDTH-1:0]    fifoctrl_wdata_i,
    input  logic                     fifoctrl_pop_i,
    output logic [DATA_WIDTH-1:0]    fifoctrl_rdata_o,
    output logic                     fifoctrl_rvalid_o,
    output logic                     fifoctrl_full_o,
    output logic                     fifoctrl_empty_o,
    output logic [ADDRESS_WIDTH:0]   fifoctrl_count_o,
    output logic                     fifoctrl_ovf_o,
    output logic                     fifoctrl_udf_o,
    output logic                     fifoctrl_afull_o,
    output logic                     fifoctrl_aempty_o
);

    localparam int PTR_W = ADDRESS_WIDTH + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count;
    logic             rvalid;
    logic             ovf;
    logic             udf;

    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] count_nxt;
    logic             push_acc;
    logic             pop_acc;
    logic             ram_we;
    logic             full;
    logic             empty;

    // Flags come only from registered pointers, never from push/pop.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDRESS_WIDTH] != rd_ptr[ADDRESS_WIDTH]) &&
                   (wr_ptr[ADDRESS_WIDTH-1:0] == rd_ptr[ADDRESS_WIDTH-1:0]);

    // Accept decisions and next pointer state; flush overrides everything.
    always_comb begin
        push_acc   = fifoctrl_push_i & ~full;
        pop_acc    = fifoctrl_pop_i & ~empty;
        ram_we     = push_acc & ~fifoctrl_flush_i;
        wr_ptr_nxt = wr_ptr + PTR_W'(push_acc);
        rd_ptr_nxt = rd_ptr + PTR_W'(pop_acc);
        if (fifoctrl_flush_i) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    // Pointer, occupancy, read-valid and sticky error flag registers.
    always_ff @(posedge fifoctrl_clk_i or negedge fifoctrl_rstn_i) begin
        if (!fifoctrl_rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rvalid <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (fifoctrl_flush_i) begin
                rvalid <= 1'b0;
                ovf    <= 1'b0;
                udf    <= 1'b0;
            end else begin
                rvalid <= pop_acc;
                ovf    <= ovf | (fifoctrl_push_i & full);
                udf    <= udf | (fifoctrl_pop_i & empty);
            end
        end
    end

`ifdef FIFOCTRL_THRESH_EN
    localparam logic [PTR_W-1:0] AFULL_L  = PTR_W'(AFULL_LEVEL);
    localparam logic [PTR_W-1:0] AEMPTY_L = PTR_W'(AEMPTY_LEVEL);

    logic afull;
    logic aempty;

    // Thresholds use the next count so they change on the same edge as count.
    always_ff @(posedge fifoctrl_clk_i or negedge fifoctrl_rstn_i) begin
        if (!fifoctrl_rstn_i) begin
            afull  <= 1'b0;
            aempty <= 1'b1;
        end else begin
            afull  <= (count_nxt >= AFULL_L);
            aempty <= (count_nxt <= AEMPTY_L);
        end
    end

    assign fifoctrl_afull_o  = afull;
    assign fifoctrl_aempty_o = aempty;
`else
    assign fifoctrl_afull_o  = 1'b0;
    assign fifoctrl_aempty_o = 1'b0;
`endif

    // Storage: read address follows rd_ptr continuously, so rdata in the
    // cycle after a pop is the word at the pre-increment pointer.
    ram_dual #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram (
        .clk   (fifoctrl_clk_i),
        .we    (ram_we),
        .waddr (wr_ptr[ADDRESS_WIDTH-1:0]),
        .wdata (fifoctrl_wdata_i),
        .raddr (rd_ptr[ADDRESS_WIDTH-1:0]),
        .rdata (fifoctrl_rdata_o)
    );

    assign fifoctrl_rvalid_o = rvalid;
    assign fifoctrl_full_o   = full;
    assign fifoctrl_empty_o  = empty;
    assign fifoctrl_count_o  = count;
    assign fifoctrl_ovf_o    = ovf;
    assign fifoctrl_udf_o    = udf;

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with an 8-deep, 8-bit configuration.
module tb_fifo_ctrl;

    localparam int AW = 3;
    localparam int DW = 8;

`ifdef FIFOCTRL_THRESH_EN
    localparam logic AEMPTY_RST = 1'b1;
`else
    localparam logic AEMPTY_RST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic          push;
    logic [DW-1:0] wdata;
    logic          pop;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;
    logic          afull;
    logic          aempty;

    int errors = 0;
    int checks = 0;

    fifo_ctrl #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .AFULL_LEVEL   (6),
        .AEMPTY_LEVEL  (1)
    ) dut (
        .fifoctrl_clk_i    (clk),
        .fifoctrl_rstn_i   (rstn),
        .fifoctrl_flush_i  (flush),
        .fifoctrl_push_i   (push),
        .fifoctrl_wdata_i  (wdata),
        .fifoctrl_pop_i    (pop),
        .fifoctrl_rdata_o  (rdata),
        .fifoctrl_rvalid_o (rvalid),
        .fifoctrl_full_o   (full),
        .fifoctrl_empty_o  (empty),
        .fifoctrl_count_o  (count),
        .fifoctrl_ovf_o    (ovf),
        .fifoctrl_udf_o    (udf),
        .fifoctrl_afull_o  (afull),
        .fifoctrl_aempty_o (aempty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic pu, input logic po, input logic fl, input logic [DW-1:0] wd);
        push  = pu;
        pop   = po;
        flush = fl;
        wdata = wd;
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rstn  = 1'b0;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty",  32'(empty),  32'd1);
        chk("rst_full",   32'(full),   32'd0);
        chk("rst_count",  32'(count),  32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_ovf",    32'(ovf),    32'd0);
        chk("rst_udf",    32'(udf),    32'd0);
        chk("rst_afull",  32'(afull),  32'd0);
        chk("rst_aempty", 32'(aempty), 32'(AEMPTY_RST));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single push then pop
        cyc(1'b1, 1'b0, 1'b0, 8'hA5);
        chk("t1_count1", 32'(count),  32'd1);
        chk("t1_empty0", 32'(empty),  32'd0);
        chk("t1_rv0",    32'(rvalid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t1_rv1",    32'(rvalid), 32'd1);
        chk("t1_rdata",  32'(rdata),  32'hA5);
        chk("t1_count0", 32'(count),  32'd0);
        chk("t1_empty1", 32'(empty),  32'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t1_rv_drop", 32'(rvalid), 32'd0);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
        chk("t2_full",  32'(full),  32'd1);
        chk("t2_count", 32'(count), 32'd8);
        cyc(1'b1, 1'b0, 1'b0, 8'hFF);
        chk("t2_ovf",     32'(ovf),   32'd1);
        chk("t2_count_h", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("t2_rv%0d", i),    32'(rvalid), 32'd1);
            chk($sformatf("t2_rdata%0d", i), 32'(rdata),  32'(i));
        end
        chk("t2_empty",  32'(empty), 32'd1);
        chk("t2_sticky", 32'(ovf),   32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t2_flush_ovf", 32'(ovf), 32'd0);

        // Wrap-around: move pointers to 6 then write across address 7 -> 0
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i));
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("t3_pre%0d", i), 32'(rdata), 32'h20 + 32'(i));
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
            chk($sformatf("t3_full%0d", i), 32'(full), 32'(i == 7));
        end
        chk("t3_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("t3_rdata%0d", i), 32'(rdata), 32'h10 + 32'(i));
        end

        // Underflow, and push+pop on empty
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t4_udf",   32'(udf),    32'd1);
        chk("t4_rv0",   32'(rvalid), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 8'h33);
        chk("t4_count1", 32'(count),  32'd1);
        chk("t4_udf_s",  32'(udf),    32'd1);
        chk("t4_nobyp",  32'(rvalid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t4_rv1",    32'(rvalid), 32'd1);
        chk("t4_rdata",  32'(rdata),  32'h33);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t4_flush_udf", 32'(udf), 32'd0);

        // Full with simultaneous push and pop, then flush with push
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
        cyc(1'b1, 1'b1, 1'b0, 8'h99);
        chk("t5_rv",     32'(rvalid), 32'd1);
        chk("t5_rdata",  32'(rdata),  32'h40);
        chk("t5_ovf",    32'(ovf),    32'd1);
        chk("t5_count7", 32'(count),  32'd7);
        chk("t5_full0",  32'(full),   32'd0);
        cyc(1'b1, 1'b0, 1'b1, 8'h77);
        chk("t5_fl_count", 32'(count),  32'd0);
        chk("t5_fl_empty", 32'(empty),  32'd1);
        chk("t5_fl_ovf",   32'(ovf),    32'd0);
        chk("t5_fl_udf",   32'(udf),    32'd0);
        chk("t5_fl_rv",    32'(rvalid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t5_fl_hold", 32'(count), 32'd0);

`ifdef FIFOCTRL_THRESH_EN
        // Threshold flags track count
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'h50 + 8'(i));
        chk("t6_afull0", 32'(afull), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h55);
        chk("t6_afull1", 32'(afull), 32'd1);
        chk("t6_count6", 32'(count), 32'd6);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t6_aempty0", 32'(aempty), 32'd0);
        chk("t6_afull_c", 32'(afull),  32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t6_aempty1", 32'(aempty), 32'd1);
        chk("t6_count1",  32'(count),  32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
`endif

        // Asynchronous reset in the middle of a burst
        cyc(1'b1, 1'b0, 1'b0, 8'h61);
        cyc(1'b1, 1'b0, 1'b0, 8'h62);
        push = 1'b1;
        pop  = 1'b1;
        wdata = 8'h63;
        @(posedge clk);
        #2;
        chk("t7_pre_rv", 32'(rvalid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("t7_rv",     32'(rvalid), 32'd0);
        chk("t7_count",  32'(count),  32'd0);
        chk("t7_empty",  32'(empty),  32'd1);
        chk("t7_full",   32'(full),   32'd0);
        chk("t7_afull",  32'(afull),  32'd0);
        chk("t7_aempty", 32'(aempty), 32'(AEMPTY_RST));
        push = 1'b0;
        pop  = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t7_after", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_ctrl
